// File: rtl/reg_mem_responder_pkg.sv
// reg_mem_responder_pkg: shared FSM state type and counter width for the memory responder.
package reg_mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACK, DROP} resp_state_e;
  localparam int CNT_W = $clog2(16);
endpackage

// File: rtl/reg_mem_responder.sv
// reg_mem_responder: native-clock memory target with programmable ack latency and a flop storage array.
module reg_mem_responder
  import reg_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                  native_clk,
  input  logic                  native_rst_n,
  input  logic                  soft_rst,
  input  logic                  req_vld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  err,
  output logic                  busy
);
  resp_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic wr_q, rd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ex_addr;
  logic ex_wr, ex_rd, in_range, go;
  logic [DATA_WIDTH-1:0] ex_data;
  // With LATENCY=1 the access executes at the accept edge, so live inputs are used
  always_comb begin
    ex_addr = state == IDLE ? addr : addr_q;
    ex_wr = state == IDLE ? wr_en : wr_q;
    ex_rd = state == IDLE ? rd_en : rd_q;
    ex_data = state == IDLE ? wr_data : data_q;
    in_range = 32'(ex_addr) < DEPTH;
    go = state == IDLE ? req_vld && LATENCY == 1 : state == WAIT && cnt == CNT_W'(1);
  end
  always_ff @(posedge native_clk or negedge native_rst_n) begin
    if (!native_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ack_vld <= 1'b0;
      err <= 1'b0;
      rd_data <= '0;
      busy <= 1'b0;
      addr_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      data_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (soft_rst) begin
      state <= IDLE;
      cnt <= '0;
      ack_vld <= 1'b0;
      err <= 1'b0;
      rd_data <= '0;
      busy <= 1'b0;
    end else begin
      ack_vld <= go;
      if (go) begin
        err <= !in_range;
        rd_data <= !in_range ? ERR_DATA : ex_rd ? mem[ex_addr] : '0;
        if (in_range && ex_wr) mem[ex_addr] <= ex_data;
      end
      case (state)
        IDLE: if (req_vld) begin
          addr_q <= addr;
          wr_q <= wr_en;
          rd_q <= rd_en;
          data_q <= wr_data;
          cnt <= CNT_W'(LATENCY - 1);
          state <= LATENCY == 1 ? ACK : WAIT;
          busy <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (go) state <= ACK;
        end
        ACK: begin
          state <= req_vld ? DROP : IDLE;
          busy <= req_vld;
        end
        DROP: if (!req_vld) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_mem_responder.sv
// tb_reg_mem_responder: directed checks of latency, storage, error, drop and soft-reset behaviour.
module tb_reg_mem_responder;
  logic native_clk = 1'b0, native_rst_n = 1'b0, soft_rst = 1'b0;
  logic req_vld = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] addr = '0;
  logic [63:0] wr_data = '0;
  logic [3:0] ack, err, busy;
  logic [63:0] rd [4];
  int errors = 0, checks = 0, lat_got, acks;
  logic [63:0] rd_got;
  logic err_got;

  always #5 native_clk = ~native_clk;

  // 0: L2/D16, 1: L2/D12, 2: L1/D16, 3: L15/D16, all sharing the request inputs
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = g == 2 ? 1 : g == 3 ? 15 : 2;
    localparam int DEP = g == 1 ? 12 : 16;
    reg_mem_responder #(.LATENCY(LAT), .DEPTH(DEP)) u_dut (
      .native_clk(native_clk), .native_rst_n(native_rst_n), .soft_rst(soft_rst),
      .req_vld(req_vld), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
      .ack_vld(ack[g]), .rd_data(rd[g]), .err(err[g]), .busy(busy[g]));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 4'b0 && n < 60) begin
      @(negedge native_clk);
      n++;
    end
  endtask

  task automatic xact(input int idx, input logic [3:0] a, input logic w, input logic r,
                      input logic [63:0] d, input int hold);
    wait_idle();
    addr = a; wr_en = w; rd_en = r; wr_data = d; req_vld = 1'b1;
    lat_got = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge native_clk);
      if (ack[idx]) begin
        lat_got = i;
        break;
      end
    end
    rd_got = rd[idx];
    err_got = err[idx];
    for (int i = 0; i < hold; i++) begin
      @(negedge native_clk);
      chk("drop_busy", 64'(busy[idx]), 64'd1);
      chk("drop_noack", 64'(ack[idx]), 64'd0);
    end
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge native_clk);
    chk("rst_ack", 64'(ack[0]), 64'd0);
    chk("rst_err", 64'(err[0]), 64'd0);
    chk("rst_rd", rd[0], 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    native_rst_n = 1'b1;
    @(negedge native_clk);
    xact(0, 4'd3, 1'b1, 1'b0, 64'h1122_3344_5566_7788, 0);
    chk("wr3_lat", 64'(lat_got), 64'd2);
    chk("wr3_err", 64'(err_got), 64'd0);
    chk("wr3_rd", rd_got, 64'd0);
    xact(0, 4'd3, 1'b0, 1'b1, 64'd0, 0);
    chk("rd3_lat", 64'(lat_got), 64'd2);
    chk("rd3_data", rd_got, 64'h1122_3344_5566_7788);
    chk("rd3_err", 64'(err_got), 64'd0);
    xact(1, 4'd0, 1'b1, 1'b0, 64'hCAFE, 0);
    xact(1, 4'd15, 1'b0, 1'b1, 64'd0, 0);
    chk("oor_err", 64'(err_got), 64'd1);
    chk("oor_data", rd_got, 64'hDEAD_BEEF_DEAD_BEEF);
    xact(1, 4'd0, 1'b0, 1'b1, 64'd0, 0);
    chk("rd0_data", rd_got, 64'hCAFE);
    chk("rd0_err", 64'(err_got), 64'd0);
    xact(0, 4'd9, 1'b1, 1'b0, 64'h77, 3);
    chk("drop_lat", 64'(lat_got), 64'd2);
    @(negedge native_clk);
    chk("drop_idle", 64'(busy[0]), 64'd0);
    xact(0, 4'd9, 1'b0, 1'b1, 64'd0, 0);
    chk("rd9_data", rd_got, 64'h77);
    xact(0, 4'd5, 1'b1, 1'b0, 64'h5A, 0);
    wait_idle();
    addr = 4'd5; wr_en = 1'b1; wr_data = 64'hA5; req_vld = 1'b1;
    @(negedge native_clk);
    soft_rst = 1'b1; req_vld = 1'b0; wr_en = 1'b0;
    @(negedge native_clk);
    soft_rst = 1'b0;
    chk("srst_busy", 64'(busy[0]), 64'd0);
    chk("srst_ack", 64'(ack[0]), 64'd0);
    acks = 0;
    repeat (4) begin
      @(negedge native_clk);
      acks += int'(ack[0]);
    end
    chk("srst_noack", 64'(acks), 64'd0);
    xact(0, 4'd5, 1'b0, 1'b1, 64'd0, 0);
    chk("rd5_kept", rd_got, 64'h5A);
    xact(0, 4'd7, 1'b1, 1'b0, 64'h1, 0);
    xact(0, 4'd7, 1'b1, 1'b1, 64'h2, 0);
    chk("rbw_old", rd_got, 64'h1);
    chk("rbw_err", 64'(err_got), 64'd0);
    xact(0, 4'd7, 1'b0, 1'b1, 64'd0, 0);
    chk("rbw_new", rd_got, 64'h2);
    xact(2, 4'd3, 1'b0, 1'b1, 64'd0, 0);
    chk("lat1", 64'(lat_got), 64'd1);
    chk("lat1_data", rd_got, 64'h1122_3344_5566_7788);
    xact(3, 4'd3, 1'b0, 1'b1, 64'd0, 0);
    chk("lat15", 64'(lat_got), 64'd15);
    chk("lat15_data", rd_got, 64'h1122_3344_5566_7788);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
